// File: rtl/regfile_debug_port.sv
// regfile_debug_port: host-side read/write/dump initiator for the 32x32 register file.
// Rev 1.0
`default_nettype none

module regfile_debug_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_addr,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_we
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR        = 4'd1,
    RD_ISSUE  = 4'd2,
    RD_CAP    = 4'd3,
    RSP       = 4'd4,
    DMP_ISSUE = 4'd5,
    DMP_CAP   = 4'd6,
    DMP_A     = 4'd7,
    DMP_B     = 4'd8
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  k;
  logic [3:0]  k_inc;
  logic [31:0] dump_hold;
  logic        cmd_fire;

  assign cmd_ready = rst && (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RSP) || (state == DMP_A) || (state == DMP_B);
  assign rsp_last  = (state == RSP) || ((state == DMP_B) && (k == 4'd15));
  assign rf_we     = (state == WR);
  assign k_inc     = k + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_READ:  state_nx = RD_ISSUE;
            OP_WRITE: state_nx = WR;
            OP_DUMP:  state_nx = DMP_ISSUE;
            default:  state_nx = IDLE;
          endcase
        end
      end
      WR:        state_nx = IDLE;
      RD_ISSUE:  state_nx = RD_CAP;
      RD_CAP:    state_nx = RSP;
      RSP:       if (rsp_ready) state_nx = IDLE;
      DMP_ISSUE: state_nx = DMP_CAP;
      DMP_CAP:   state_nx = DMP_A;
      DMP_A:     if (rsp_ready) state_nx = DMP_B;
      DMP_B:     if (rsp_ready) state_nx = (k == 4'd15) ? IDLE : DMP_ISSUE;
      default:   state_nx = IDLE;
    endcase
  end

  // Read addresses are set one state ahead so the register file's registered
  // read data is ready exactly when the capture state samples it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k         <= 4'd0;
      dump_hold <= 32'd0;
      rsp_addr  <= 5'd0;
      rsp_data  <= 32'd0;
      rf_raddr1 <= 5'd0;
      rf_raddr2 <= 5'd0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_READ: rf_raddr1 <= cmd_addr;
              OP_WRITE: begin
                rf_waddr <= cmd_addr;
                rf_wdata <= cmd_wdata;
              end
              OP_DUMP: begin
                k         <= 4'd0;
                rf_raddr1 <= 5'd0;
                rf_raddr2 <= 5'd1;
              end
              default: ;
            endcase
          end
        end
        RD_CAP: begin
          rsp_data <= rf_rdata1;
          rsp_addr <= rf_raddr1;
        end
        DMP_CAP: begin
          rsp_data  <= rf_rdata1;
          dump_hold <= rf_rdata2;
          rsp_addr  <= {k, 1'b0};
        end
        DMP_A: begin
          if (rsp_ready) begin
            rsp_data <= dump_hold;
            rsp_addr <= {k, 1'b1};
          end
        end
        DMP_B: begin
          if (rsp_ready && (k != 4'd15)) begin
            k         <= k_inc;
            rf_raddr1 <= {k_inc, 1'b0};
            rf_raddr2 <= {k_inc, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_debug_port.sv
// tb_regfile_debug_port: self-checking bench for regfile_debug_port with a behavioural register file.
// Rev 1.0
`default_nettype none

module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_addr = 5'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1 = 32'd0, rf_rdata2 = 32'd0, rf_wdata;
  logic        rf_we;

  regfile_debug_port dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we)
  );

  always #5 clk = ~clk;

  // Register file environment: synchronous write, registered 1-cycle reads.
  logic [31:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    rf_rdata1 <= rf_mem[rf_raddr1];
    rf_rdata2 <= rf_mem[rf_raddr2];
  end

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_beats;
    int          exp_we;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_cyc = 0;
  int          beat_count = 0;
  int          last_count = 0;
  int          we_count = 0;
  int          bp_mode = 0;
  logic [31:0] ref_mem [32];
  beat_t       exp_q [$];
  beat_t       mon_b;
  vec_t        vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // 0: always ready, 1: random backpressure, 2: held off
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  always @(negedge clk) if (rf_we) we_count++;

  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      beat_count++;
      if (rsp_last) begin
        last_count++;
        last_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %0d data %0h, none expected", rsp_addr, rsp_data);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_addr", 64'(rsp_addr), 64'(mon_b.addr));
        check("beat_data", 64'(rsp_data), 64'(mon_b.data));
        check("beat_last", 64'(rsp_last), 64'(mon_b.last));
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 2000 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  // Reference behaviour: registers as a plain array; responses as a beat list.
  task automatic model_accept(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    case (op)
      2'b00: exp_q.push_back('{addr: a, data: ref_mem[a], last: 1'b1});
      2'b01: ref_mem[a] = d;
      2'b10: for (int i = 0; i < 32; i++)
               exp_q.push_back('{addr: 5'(i), data: ref_mem[i], last: (i == 31)});
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    send_cmd(op, a, d);
    model_accept(op, a, d);
  endtask

  task automatic wait_done();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_in_budget", 64'(n < 3000), 64'd1);
  endtask

  initial begin
    int b0, w0, l0, n;
    logic found;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;

    vecs[0] = '{op: 2'b01, addr: 5'd0,  wdata: 32'h1,        exp_data: 32'h0,        exp_beats: 0, exp_we: 1};
    vecs[1] = '{op: 2'b00, addr: 5'd0,  wdata: 32'h0,        exp_data: 32'h1,        exp_beats: 1, exp_we: 0};
    vecs[2] = '{op: 2'b01, addr: 5'd31, wdata: 32'hFFFFFFFF, exp_data: 32'h0,        exp_beats: 0, exp_we: 1};
    vecs[3] = '{op: 2'b00, addr: 5'd31, wdata: 32'h0,        exp_data: 32'hFFFFFFFF, exp_beats: 1, exp_we: 0};
    vecs[4] = '{op: 2'b11, addr: 5'd31, wdata: 32'h0,        exp_data: 32'h0,        exp_beats: 0, exp_we: 0};
    vecs[5] = '{op: 2'b00, addr: 5'd31, wdata: 32'h0,        exp_data: 32'hFFFFFFFF, exp_beats: 1, exp_we: 0};
    vecs[6] = '{op: 2'b00, addr: 5'd5,  wdata: 32'h0,        exp_data: 32'hDEADBEEF, exp_beats: 1, exp_we: 0};
    vecs[7] = '{op: 2'b01, addr: 5'd5,  wdata: 32'h0,        exp_data: 32'h0,        exp_beats: 0, exp_we: 1};
    vecs[8] = '{op: 2'b00, addr: 5'd5,  wdata: 32'h0,        exp_data: 32'h0,        exp_beats: 1, exp_we: 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rsp_addr_data", {27'd0, rsp_addr, rsp_data}, 64'd0);
    check("rst_raddrs", {54'd0, rf_raddr1, rf_raddr2}, 64'd0);
    check("rst_write_port", {27'd0, rf_waddr, rf_wdata}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write 5 then read 5 with cycle-exact latency
    do_cmd(2'b01, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_we_high", 64'(rf_we), 64'd1);
    check("wr_port", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd5, 32'hDEADBEEF});
    check("wr_busy", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("wr_we_low", 64'(rf_we), 64'd0);
    check("wr_ready_again", 64'(cmd_ready), 64'd1);
    do_cmd(2'b00, 5'd5, 32'd0);
    @(negedge clk);
    check("rd_raddr1", 64'(rf_raddr1), 64'd5);
    check("rd_lat_e0", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("rd_lat_e1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("rd_lat_e2", 64'(rsp_valid), 64'd1);
    wait_done();

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      b0 = beat_count;
      w0 = we_count;
      send_cmd(vecs[v].op, vecs[v].addr, vecs[v].wdata);
      if (vecs[v].op == 2'b01) ref_mem[vecs[v].addr] = vecs[v].wdata;
      if (vecs[v].op == 2'b00) exp_q.push_back('{addr: vecs[v].addr, data: vecs[v].exp_data, last: 1'b1});
      wait_done();
      check($sformatf("vec%0d_beats", v), 64'(beat_count - b0), 64'(vecs[v].exp_beats));
      check($sformatf("vec%0d_we", v), 64'(we_count - w0), 64'(vecs[v].exp_we));
    end

    // Back-to-back write then read of the same register
    do_cmd(2'b01, 5'd3, 32'h55);
    do_cmd(2'b00, 5'd3, 32'd0);
    wait_done();

    // Backpressure with a busy-time write attempt
    do_cmd(2'b01, 5'd7, 32'h12345678);
    wait_done();
    w0 = we_count;
    b0 = beat_count;
    bp_mode = 2;
    do_cmd(2'b00, 5'd7, 32'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd7; cmd_wdata = 32'h0;
      end
      if (i == 3) cmd_valid = 1'b0;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data", 64'(rsp_data), 64'h12345678);
      check("bp_addr", 64'(rsp_addr), 64'd7);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    bp_mode = 0;
    wait_done();
    check("bp_one_beat", 64'(beat_count - b0), 64'd1);
    check("busy_write_ignored", 64'(we_count - w0), 64'd0);
    do_cmd(2'b00, 5'd7, 32'd0);
    wait_done();

    // Full dump with continuous ready
    for (int i = 0; i < 32; i++) do_cmd(2'b01, 5'(i), 32'hA5000000 + 32'(i));
    wait_done();
    b0 = beat_count;
    l0 = last_count;
    do_cmd(2'b10, 5'd0, 32'd0);
    wait_done();
    check("dump_beats", 64'(beat_count - b0), 64'd32);
    check("dump_last_once", 64'(last_count - l0), 64'd1);
    check("dump_cycles", 64'(last_cyc - acc_cyc + 1), 64'd64);

    // Random commands under random backpressure
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10 && $urandom_range(0, 3) != 0) op = 2'b00;
      do_cmd(op, 5'($urandom_range(0, 31)), $urandom);
    end
    wait_done();
    bp_mode = 0;

    // Reset in DMP_A of pair 4
    b0 = beat_count;
    do_cmd(2'b10, 5'd0, 32'd0);
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      @(posedge clk);
      #2;
      n++;
      if (rsp_valid && rsp_addr == 5'd8) found = 1'b1;
    end
    check("mid_dump_reached", 64'(found), 64'd1);
    rst = 1'b0;
    bp_mode = 2;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("mid_dump_beats_before", 64'(beat_count - b0), 64'd8);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    bp_mode = 0;
    b0 = beat_count;
    repeat (20) @(negedge clk);
    check("no_resume_beats", 64'(beat_count - b0), 64'd0);
    check("post_rst_idle", 64'(cmd_ready), 64'd1);
    do_cmd(2'b00, 5'd9, 32'd0);
    wait_done();
    check("post_rst_read_beat", 64'(beat_count - b0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
